regfile_2r1w_sb: RTL and testbench
==================================

Name: regfile_2r1w_sb

Overview:
- MIPS general-purpose register file for the pipelined core: 32 x 32-bit registers.
- Read side: two asynchronous read ports feed the ID stage.
- Write side: one synchronous write port is driven by WB.
- An integrated per-register busy scoreboard lets the hazard unit stall ID while a register still has an uncommitted in-flight write.

Parameters:
- DW, 32, data width in bits.
- NREG, 32, number of architectural registers (power of two).
- AW, 5, register index width = log2(NREG).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- rs_addr  in  AW  read port A index.
- rt_addr  in  AW  read port B index.
- rs_data  out  DW  read port A data.
- rt_data  out  DW  read port B data.
- rs_busy  out  1  read port A register has a pending write.
- rt_busy  out  1  read port B register has a pending write.
- wb_en  in  1  write enable from WB.
- wb_addr  in  AW  write index.
- wb_data  in  DW  write data.
- iss_en  in  1  an instruction with a destination leaves ID this cycle.
- iss_addr  in  AW  destination of the issuing instruction.
- sb_clear  in  1  synchronous clear of all busy bits (pipeline flush).

Behaviour:
- Reset (rst=0, asynchronous):
  - all registers = 0, all busy bits = 0.
  - hence rs_data = rt_data = 0 and rs_busy = rt_busy = 0 for any address.
  - Reset asserted mid-operation discards any write in that cycle.
- Storage write: on posedge clk, if wb_en=1 and wb_addr != 0, then reg[wb_addr] <= wb_data. Writes to index 0 are ignored.
- Read: combinational. reg[0] always reads 0.
  - rs_data = (rs_addr==0) ? 0 : reg[rs_addr]; same form for rt.
  - Both ports may address the same register; both return identical data.
- Busy bit busy[i], updated each posedge:
  - Set when iss_en=1 and iss_addr==i.
  - Cleared when wb_en=1 and wb_addr==i.
  - Set and clear of the same index in the same cycle: the set wins (a newer producer has issued).
  - sb_clear=1 clears every bit. It overrides a set in the same cycle.
  - busy[0] is never set.
- rs_busy = busy[rs_addr] and rt_busy = busy[rt_addr], combinational. These are the values registered before this edge; a same-cycle WB clear is only reflected via the bypass feature.
- Latency:
  - A write is visible on the read ports the cycle after the WB edge (without bypass).
  - A busy set is visible the cycle after issue.
- One outstanding write per register is tracked. Reissuing to an already-busy register leaves it busy; the first WB to it clears it. The pipeline guarantees in-order WB.
- No X propagation: unused addresses do not exist (NREG = 2^AW).

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined:
  - Write-through forwarding. If wb_en=1 and wb_addr==rs_addr != 0, rs_data = wb_data combinationally and rs_busy = 0. Same for rt.
  - This allows ID to consume a register in the same cycle WB writes it.
- Undefined:
  - Reads return stored values only. rs_busy stays 1 during the WB cycle; the hazard unit stalls one extra cycle.

Decomposition:
- Shared package/header (mips_pkg):
  - REG_ZERO = 0, DW, AW constants.
  - Reg-index type.
- Sub-module sb_bits holds the NREG-bit busy vector with the set/clear/flush priority logic. Storage and read muxing stay in the top module.

Test Plan:
1. Reset and zero register:
   - rst=0, then release; read all 32 indices → data 0, busy 0.
   - Write 0xDEADBEEF to r0 → r0 still reads 0.
2. Write/read:
   - wb_en=1, wb_addr=5, wb_data=0x12345678 → next cycle rs_addr=5 and rt_addr=5 both read 0x12345678.
   - r6 is unchanged (0).
3. Scoreboard:
   - iss_en=1, iss_addr=9 → next cycle rs_busy=1 for rs_addr=9.
   - WB to r9 with 0xA5A5A5A5 → one cycle later busy=0 and data=0xA5A5A5A5.
4. Simultaneous events:
   - Same cycle: iss_addr=9 and wb_addr=9 → busy[9]=1 after the edge.
   - sb_clear=1 with iss_addr=3 → busy[3]=0.
5. Bypass:
   - Macro defined: wb_addr=7, wb_data=0xCAFEF00D, rs_addr=7 in the same cycle → rs_data=0xCAFEF00D, rs_busy=0 before the edge.
   - Macro undefined: old value returned and busy=1.
6. Reset mid-operation:
   - busy[4]=1, r4=0x11; assert rst between edges → immediately r4=0 and busy[4]=0, with no clock required.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS register file and its busy scoreboard.
// No logic here; consumers size their ports from these defaults.
package mips_pkg;

    localparam int DW       = 32;
    localparam int NREG     = 32;
    localparam int AW       = $clog2(NREG);
    localparam int REG_ZERO = 0;

    typedef logic [AW-1:0] reg_idx_t;
    typedef logic [DW-1:0] word_t;

endpackage

// File: rtl/regfile_2r1w_sb_sb_bits.sv
// Per-register busy scoreboard: set on issue, clear on WB, set beats clear, flush beats set.
// Latency: one edge to update; no backpressure. r0 is never marked busy.
module sb_bits #(
    parameter int NREG = mips_pkg::NREG,
    parameter int AW   = mips_pkg::AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iss_en_i,
    input  logic [AW-1:0]   iss_addr_i,
    input  logic            wb_en_i,
    input  logic [AW-1:0]   wb_addr_i,
    input  logic            sb_clear_i,
    output logic [NREG-1:0] busy_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Later assignments win: clear, then a newer producer's set, then the flush.
    always_comb begin
        busy_d = busy_q;
        if (wb_en_i) begin
            busy_d[wb_addr_i] = 1'b0;
        end
        if (iss_en_i && (iss_addr_i != AW'(mips_pkg::REG_ZERO))) begin
            busy_d[iss_addr_i] = 1'b1;
        end
        if (sb_clear_i) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_2r1w_sb.sv
// 32x32 register file, 2 async reads / 1 sync write, with busy scoreboard; writes visible next cycle.
// No backpressure (hazard unit stalls on *_busy). `REGFILE_WB_BYPASS_EN adds same-cycle WB forwarding.
module regfile_2r1w_sb #(
    parameter int DW   = mips_pkg::DW,
    parameter int NREG = mips_pkg::NREG,
    parameter int AW   = mips_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    output logic [DW-1:0] rs_data,
    output logic [DW-1:0] rt_data,
    output logic          rs_busy,
    output logic          rt_busy,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic          iss_en,
    input  logic [AW-1:0] iss_addr,
    input  logic          sb_clear
);

    localparam logic [AW-1:0] ZERO_IDX = AW'(mips_pkg::REG_ZERO);

    logic [DW-1:0]   regs_q [NREG];
    logic [NREG-1:0] busy;
    logic            wb_we;
    logic [DW-1:0]   rs_stored;
    logic [DW-1:0]   rt_stored;

    assign wb_we = wb_en && (wb_addr != ZERO_IDX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_we) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    sb_bits #(
        .NREG (NREG),
        .AW   (AW)
    ) u_sb_bits (
        .clk        (clk),
        .rst        (rst),
        .iss_en_i   (iss_en),
        .iss_addr_i (iss_addr),
        .wb_en_i    (wb_en),
        .wb_addr_i  (wb_addr),
        .sb_clear_i (sb_clear),
        .busy_o     (busy)
    );

    assign rs_stored = (rs_addr == ZERO_IDX) ? '0 : regs_q[rs_addr];
    assign rt_stored = (rt_addr == ZERO_IDX) ? '0 : regs_q[rt_addr];

`ifdef REGFILE_WB_BYPASS_EN
    logic rs_hit;
    logic rt_hit;

    // Gated by reset so an asserted reset reads all-zero regardless of WB activity.
    assign rs_hit  = rst && wb_we && (wb_addr == rs_addr);
    assign rt_hit  = rst && wb_we && (wb_addr == rt_addr);
    assign rs_data = rs_hit ? wb_data : rs_stored;
    assign rt_data = rt_hit ? wb_data : rt_stored;
    assign rs_busy = busy[rs_addr] && !rs_hit;
    assign rt_busy = busy[rt_addr] && !rt_hit;
`else
    assign rs_data = rs_stored;
    assign rt_data = rt_stored;
    assign rs_busy = busy[rs_addr];
    assign rt_busy = busy[rt_addr];
`endif

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Directed plus randomized checks of regfile_2r1w_sb against an architectural model of registers and busy bits.
module tb_regfile_2r1w_sb;

    logic        clk;
    logic        rst;
    logic [4:0]  rs_addr, rt_addr, wb_addr, iss_addr;
    logic [31:0] rs_data, rt_data, wb_data;
    logic        rs_busy, rt_busy, wb_en, iss_en, sb_clear;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_reg  [32];
    logic        m_busy [32];

    regfile_2r1w_sb dut (
        .clk      (clk),
        .rst      (rst),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .rs_busy  (rs_busy),
        .rt_busy  (rt_busy),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .sb_clear (sb_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = 32'h0;
            m_busy[i] = 1'b0;
        end
    endfunction

    function automatic logic bypass_hit(input logic [4:0] a);
        logic hit;
        hit = 1'b0;
`ifdef REGFILE_WB_BYPASS_EN
        hit = rst && wb_en && (a != 0) && (wb_addr == a);
`endif
        return hit;
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (bypass_hit(a)) return wb_data;
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (bypass_hit(a)) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_ports(input string tag);
        check({tag, ".rs_data"}, rs_data, exp_data(rs_addr));
        check({tag, ".rt_data"}, rt_data, exp_data(rt_addr));
        check({tag, ".rs_busy"}, {31'h0, rs_busy}, {31'h0, exp_busy(rs_addr)});
        check({tag, ".rt_busy"}, {31'h0, rt_busy}, {31'h0, exp_busy(rt_addr)});
    endtask

    // Architectural effect of one clock edge, straight from the rules.
    task automatic model_edge();
        if (wb_en && wb_addr != 0) m_reg[wb_addr] = wb_data;
        if (wb_en) m_busy[wb_addr] = 1'b0;
        if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
        if (sb_clear) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end
    endtask

    // Called just after a negedge: drive, check pre-edge outputs, take the edge, return at next negedge.
    task automatic cyc(input string tag,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ie, input logic [4:0] ia, input logic clr,
                       input logic [4:0] ra, input logic [4:0] rb);
        wb_en = we; wb_addr = wa; wb_data = wd;
        iss_en = ie; iss_addr = ia; sb_clear = clr;
        rs_addr = ra; rt_addr = rb;
        #1;
        check_ports(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        wb_en = 0; wb_addr = 0; wb_data = 0;
        iss_en = 0; iss_addr = 0; sb_clear = 0;
        rs_addr = 0; rt_addr = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rs_addr = 5'd17; rt_addr = 5'd31;
        #1;
        check_ports("in_reset");
        rst = 1'b1;
        @(negedge clk);

        // 1. all indices read zero and idle; r0 ignores writes
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i); rt_addr = 5'(31 - i);
            #1;
            check_ports("reset_scan");
        end
        cyc("wr_r0",   1, 5'd0, 32'hDEADBEEF, 0, 5'd0, 0, 5'd0, 5'd0);
        cyc("rd_r0",   0, 5'd0, 32'h0,        0, 5'd0, 0, 5'd0, 5'd0);
        check("r0_zero", rs_data, 32'h0);

        // 2. basic write then read on both ports
        cyc("wr_r5",   1, 5'd5, 32'h12345678, 0, 5'd0, 0, 5'd6, 5'd6);
        cyc("rd_r5",   0, 5'd0, 32'h0,        0, 5'd0, 0, 5'd5, 5'd5);
        check("r5_rs", rs_data, 32'h12345678);
        check("r5_rt", rt_data, 32'h12345678);
        cyc("rd_r6",   0, 5'd0, 32'h0,        0, 5'd0, 0, 5'd6, 5'd5);

        // 3. scoreboard set then WB clear
        cyc("iss_r9",  0, 5'd0, 32'h0,        1, 5'd9, 0, 5'd9, 5'd0);
        cyc("busy_r9", 0, 5'd0, 32'h0,        0, 5'd0, 0, 5'd9, 5'd9);
        check("r9_busy", {31'h0, rs_busy}, 32'h1);
        cyc("wb_r9",   1, 5'd9, 32'hA5A5A5A5, 0, 5'd0, 0, 5'd9, 5'd1);
        cyc("post_r9", 0, 5'd0, 32'h0,        0, 5'd0, 0, 5'd9, 5'd9);
        check("r9_idle", {31'h0, rs_busy}, 32'h0);
        check("r9_data", rs_data, 32'hA5A5A5A5);

        // 4. simultaneous set+clear (set wins), flush beats set
        cyc("iss_wb9", 1, 5'd9, 32'h00000009, 1, 5'd9, 0, 5'd9, 5'd0);
        cyc("chk9",    0, 5'd0, 32'h0,        0, 5'd0, 0, 5'd9, 5'd9);
        check("set_wins", {31'h0, rs_busy}, 32'h1);
        cyc("clr_iss3",0, 5'd0, 32'h0,        1, 5'd3, 1, 5'd3, 5'd9);
        cyc("chk3",    0, 5'd0, 32'h0,        0, 5'd0, 0, 5'd3, 5'd9);
        check("flush_wins", {31'h0, rs_busy}, 32'h0);
        cyc("iss_r0",  0, 5'd0, 32'h0,        1, 5'd0, 0, 5'd0, 5'd0);
        cyc("chk_r0b", 0, 5'd0, 32'h0,        0, 5'd0, 0, 5'd0, 5'd0);

        // 5. WB of busy r7 with same-cycle read (bypass-dependent expectation)
        cyc("iss_r7",  1, 5'd7, 32'h77777777, 1, 5'd7, 0, 5'd7, 5'd7);
        wb_en = 1; wb_addr = 5'd7; wb_data = 32'hCAFEF00D;
        iss_en = 0; iss_addr = 0; sb_clear = 0; rs_addr = 5'd7; rt_addr = 5'd0;
        #1;
`ifdef REGFILE_WB_BYPASS_EN
        check("byp_data", rs_data, 32'hCAFEF00D);
        check("byp_busy", {31'h0, rs_busy}, 32'h0);
`else
        check("nobyp_data", rs_data, 32'h77777777);
        check("nobyp_busy", {31'h0, rs_busy}, 32'h1);
`endif
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc("post_r7", 0, 5'd0, 32'h0,        0, 5'd0, 0, 5'd7, 5'd7);

        // 6. asynchronous reset between edges
        cyc("set_r4",  1, 5'd4, 32'h00000011, 1, 5'd4, 0, 5'd4, 5'd4);
        rs_addr = 5'd4; rt_addr = 5'd9; wb_en = 0; iss_en = 0;
        #1;
        check("pre_rst_r4", rs_data, 32'h00000011);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("async_r4_data", rs_data, 32'h0);
        check("async_r4_busy", {31'h0, rs_busy}, 32'h0);
        check("async_r9_busy", {31'h0, rt_busy}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Randomized traffic on a narrow address range to force collisions
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wa, ia, ra, rb;
            wa = (n % 3 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
            ia = 5'($urandom_range(0, 5));
            ra = (n % 4 == 0) ? wa : 5'($urandom_range(0, 7));
            rb = 5'($urandom_range(0, 7));
            cyc("rand", 1'($urandom_range(0, 1)), wa, $urandom,
                1'($urandom_range(0, 1)), ia, ($urandom_range(0, 15) == 0),
                ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
